// File: rtl/bits_to_bytes_packer.sv
// rtl/bits_to_bytes_packer.sv - serial bit stream to byte packer with per-message byte count
`timescale 1ns/1ps
module bits_to_bytes_packer #(
  parameter int LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] LEN_MAX = 8'(LEN);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, FINISH} state_e;

  state_e     state_q, state_d;
  logic [7:0] target_q, target_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] eff_len;

  // Requested length is clamped so a message never exceeds LEN bytes.
  assign eff_len = (len > LEN_MAX) ? LEN_MAX : len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      byte_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      byte_q     <= byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    byte_d     = byte_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          target_d   = eff_len;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 8'd0;
          byte_d     = 8'd0;
          state_d    = (eff_len == 8'd0) ? FINISH : COLLECT;
        end
      end
      COLLECT: begin
        if (bit_valid) begin
          byte_d[bit_cnt_q] = bit_in;
          bit_cnt_d         = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (byte_ready) begin
          byte_cnt_d = byte_cnt_q + 8'd1;
          // Clearing here keeps bits of the previous byte out of the next one.
          byte_d     = 8'd0;
          state_d    = (byte_cnt_d == target_q) ? FINISH : COLLECT;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bit_ready  = (state_q == COLLECT);
  assign byte_valid = (state_q == EMIT);
  assign busy       = (state_q == COLLECT) || (state_q == EMIT);
  assign done       = (state_q == FINISH);
  assign byte_out   = byte_q;

endmodule

// File: tb/tb_bits_to_bytes_packer.sv
// tb/tb_bits_to_bytes_packer.sv - self-checking bench for bits_to_bytes_packer
`timescale 1ns/1ps
module tb_bits_to_bytes_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       byte_ready = 1'b1;
  logic       bit_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       busy;
  logic       done;

  bits_to_bytes_packer #(.LEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int byte_seen = 0;
  int done_seen = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted output byte is popped against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid && byte_ready) begin
        total++;
        byte_seen++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte actual=%02h required=none", byte_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (byte_out !== mon_exp) begin
            bad++;
            $display("FAIL byte_out actual=%02h required=%02h", byte_out, mon_exp);
          end
        end
      end
      if (done) done_seen++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bit_valid = 1'b1;
    bit_in    = b;
    forever begin
      @(negedge clk);
      if (bit_ready) begin
        tick();
        break;
      end
      tick();
      n++;
      if (n > 50) begin
        check("bit_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit push);
    if (push) exp_q.push_back(v);
    for (int k = 0; k < 8; k++) send_bit(v[k]);
    bit_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int n;
    n = 0;
    while (done_seen <= base && n < limit) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done_seen > base), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  len;
    logic [31:0] data;
    int          nbytes;
  } vec_t;

  vec_t vt[4];
  int   db, bb, s;
  int   seq_ef[8];
  int   seq_aa[8];

  initial begin
    vt[0] = '{8'd1, 32'h000000EF, 1};
    vt[1] = '{8'd2, 32'h0000FF01, 2};
    vt[2] = '{8'd3, 32'h0000C35A, 3};
    vt[3] = '{8'd4, 32'h807E00A5, 4};
    seq_ef = '{1, 1, 1, 1, 0, 1, 1, 1};
    seq_aa = '{0, 1, 0, 1, 0, 1, 0, 1};

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_bit_ready", 32'(bit_ready), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      db = done_seen;
      bb = byte_seen;
      start_msg(vt[i].len);
      for (int j = 0; j < vt[i].nbytes; j++) send_byte(vt[i].data[8*j +: 8], 1'b1);
      wait_done(db, 40);
      check("vec_bytes", 32'(byte_seen - bb), 32'(vt[i].nbytes));
      check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
      check("vec_idle_busy", 32'(busy), 32'd0);
      tick();
      check("vec_done_once", 32'(done_seen - db), 32'd1);
    end

    // Single byte, explicit bit list, byte_valid and done each for one cycle.
    db = done_seen;
    start_msg(8'd1);
    exp_q.push_back(8'hEF);
    for (int k = 0; k < 8; k++) send_bit(seq_ef[k][0]);
    bit_valid = 1'b0;
    @(negedge clk);
    check("ef_byte_valid", 32'(byte_valid), 32'd1);
    check("ef_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("ef_valid_drop", 32'(byte_valid), 32'd0);
    check("ef_done", 32'(done), 32'd1);
    tick();
    @(negedge clk);
    check("ef_done_drop", 32'(done), 32'd0);
    check("ef_done_count", 32'(done_seen - db), 32'd1);
    tick();

    // Backpressure on the first byte of a two-byte message.
    db = done_seen;
    bb = byte_seen;
    byte_ready = 1'b0;
    start_msg(8'd2);
    send_byte(8'h01, 1'b1);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(byte_valid), 32'd1);
      check("bp_hold", 32'(byte_out), 32'h01);
      check("bp_bit_ready", 32'(bit_ready), 32'd0);
      tick();
    end
    byte_ready = 1'b1;
    send_byte(8'hFF, 1'b1);
    wait_done(db, 40);
    tick();
    check("bp_bytes", 32'(byte_seen - bb), 32'd2);
    check("bp_done_once", 32'(done_seen - db), 32'd1);

    // Zero-length message; a start during FINISH must be ignored.
    db = done_seen;
    bb = byte_seen;
    start_msg(8'd0);
    start = 1'b1;
    len   = 8'd1;
    @(negedge clk);
    check("z_done", 32'(done), 32'd1);
    check("z_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("z_done_drop", 32'(done), 32'd0);
    check("z_finish_start_ignored", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    check("z_still_idle", 32'(bit_ready), 32'd0);
    tick();
    check("z_bytes", 32'(byte_seen - bb), 32'd0);
    check("z_done_once", 32'(done_seen - db), 32'd1);

    // Oversized request is clamped to 32 bytes at full throughput.
    db = done_seen;
    bb = byte_seen;
    start_msg(8'd40);
    s = cyc;
    for (int j = 0; j < 32; j++) send_byte(8'((j * 37 + 5) & 8'hFF), 1'b1);
    wait_done(db, 40);
    check("cl_bytes", 32'(byte_seen - bb), 32'd32);
    check("cl_duration_ok", 32'((cyc - s + 1) <= 32 * 9 + 2), 32'd1);
    tick();
    check("cl_done_once", 32'(done_seen - db), 32'd1);

    // Reset in the middle of a byte.
    start_msg(8'd1);
    for (int k = 0; k < 5; k++) send_bit(1'b1);
    rst = 1'b1;
    bit_valid = 1'b0;
    #1;
    check("mr_bit_ready", 32'(bit_ready), 32'd0);
    check("mr_byte_valid", 32'(byte_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_byte_out", 32'(byte_out), 32'd0);
    tick();
    rst = 1'b0;
    db = done_seen;
    bb = byte_seen;
    repeat (3) tick();
    check("mr_no_partial", 32'(byte_seen - bb), 32'd0);
    check("mr_idle", 32'(busy), 32'd0);
    start_msg(8'd1);
    exp_q.push_back(8'hAA);
    for (int k = 0; k < 8; k++) send_bit(seq_aa[k][0]);
    bit_valid = 1'b0;
    wait_done(db, 40);
    check("mr_bytes", 32'(byte_seen - bb), 32'd1);

    // A start during COLLECT must not retarget the message.
    db = done_seen;
    bb = byte_seen;
    start_msg(8'd1);
    exp_q.push_back(8'h3C);
    for (int k = 0; k < 3; k++) send_bit(k == 2);
    bit_valid = 1'b0;
    start = 1'b1;
    len   = 8'd3;
    tick();
    start = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    bit_valid = 1'b0;
    wait_done(db, 40);
    check("sc_bytes", 32'(byte_seen - bb), 32'd1);
    check("sc_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bits_to_bytes_packer.md
BITS_TO_BYTES_PACKER -- requirements
Module: bits_to_bytes_packer

Interface
REQ-001 SHALL have parameter LEN, default 32, meaning the maximum number of bytes per message.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle request to begin a message.
REQ-005 SHALL have port len, input, 8 bits: the byte count of the message, sampled on the cycle start is accepted.
REQ-006 SHALL have port bit_in, input, 1 bit: the serial data bit.
REQ-007 SHALL have port bit_valid, input, 1 bit: bit_in holds a valid bit.
REQ-008 SHALL have port bit_ready, output, 1 bit: the block accepts bit_in.
REQ-009 SHALL have port byte_out, output, 8 bits: the packed byte.
REQ-010 SHALL have port byte_valid, output, 1 bit: byte_out is valid.
REQ-011 SHALL have port byte_ready, input, 1 bit: the sink accepts byte_out.
REQ-012 SHALL have port busy, output, 1 bit: a message is in progress.
REQ-013 SHALL have port done, output, 1 bit: a one-cycle pulse at message end.

Function
REQ-014 SHALL implement the FSM states IDLE, COLLECT, EMIT and FINISH.
REQ-015 IDLE: start=1 SHALL latch min(len, LEN) as the target, clear the bit and byte counters, and go to COLLECT; a latched len of 0 SHALL go to FINISH instead.
REQ-016 A start while not in IDLE SHALL be ignored and SHALL NOT alter the latched target.
REQ-017 bit_ready SHALL be 1 only in COLLECT.
REQ-018 A bit SHALL be accepted on a cycle where bit_valid=1 and bit_ready=1; bit_valid while bit_ready=0 SHALL be ignored.
REQ-019 Packing SHALL be LSB-first: the k-th accepted bit of a byte (k=0..7) SHALL be written into bit position k of the byte register (B = sum of b[k]*2^k).
REQ-020 The 3-bit bit counter SHALL wrap 7->0 on the 8th accepted bit, and on that same edge the state SHALL become EMIT.
REQ-021 byte_valid SHALL be 1 exactly while in EMIT, i.e. one cycle after the 8th bit is accepted.
REQ-022 byte_out SHALL hold stable while byte_valid=1 and byte_ready=0, with no bits accepted during that time.
REQ-023 On byte_valid=1 and byte_ready=1, the byte counter SHALL increment; the next state SHALL be FINISH if the count equals the target, otherwise COLLECT.
REQ-024 A byte_ready asserted with no byte_valid SHALL have no effect.
REQ-025 FINISH SHALL assert done for exactly one cycle and then return to IDLE; a start in FINISH SHALL be ignored.
REQ-026 busy SHALL be 1 in COLLECT and EMIT and 0 in IDLE and FINISH.
REQ-027 The byte register SHALL be cleared at the start of each byte, so no bits leak between bytes.
REQ-028 The minimum throughput SHALL be 1 byte per 9 cycles when bit_valid and byte_ready are held at 1.

Reset
REQ-029 Asserting rst at any time, including mid-byte or in EMIT, SHALL immediately force IDLE, clear the counters and byte_out to 0x00, and drive bit_ready=0, byte_valid=0, busy=0 and done=0.
REQ-030 After rst is released, no partial byte SHALL be emitted, and a new start SHALL be required.

Verification
REQ-031 start with len=1, then bits 1,1,1,1,0,1,1,1 with byte_ready=1 -> byte_out=0xEF with byte_valid high for 1 cycle, followed by a 1-cycle done pulse.
REQ-032 start with len=2, bits for 0x01 then 0xFF, with byte_ready held 0 for 5 cycles at the first byte -> byte_out holds 0x01 and bit_ready=0 throughout; then 0x01 and 0xFF are emitted in order and done pulses once.
REQ-033 start with len=0 -> no byte_valid, done pulses 1 cycle after start, and busy stays 0.
REQ-034 start with len=40 (LEN=32) and a continuous bit stream -> exactly 32 bytes are emitted, done fires after byte 32, and total duration is at most 32*9+2 cycles.
REQ-035 rst pulsed after 5 bits of a byte -> all outputs are at reset values; a following len=1 message with bits 0,1,0,1,0,1,0,1 yields 0xAA.
REQ-036 start pulsed in COLLECT with len=3 -> it is ignored and the original target is honoured.
